mips_cpu_alu_regfile: RTL and testbench
=======================================

# mips_cpu_alu_regfile

Datapath core of the multicycle MIPS32 bus CPU: a 32×32-bit general-purpose register file plus a combinational 32-bit ALU. The FSM controller drives it directly: it selects read/write registers, stages ALU operands and opcode, and writes results back. It also exports `$v0` for the testbench/top-level `register_v0` output.

## Interface
Parameters: none (widths fixed by MIPS32).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high. Clears all 32 registers.
- write  in  1  register write enable, sampled on posedge clk.
- wr_addr  in  5  destination register index.
- wr_data  in  32  data to write.
- rd_addr_a  in  5  read port A index (rs).
- rd_data_a  out  32  contents of register rd_addr_a.
- rd_addr_b  in  5  read port B index (rt).
- rd_data_b  out  32  contents of register rd_addr_b.
- register_v0  out  32  live contents of register 2, never bypassed.
- alu_op  in  5  ALU operation select.
- alu_a  in  32  operand A (rs value).
- alu_b  in  32  operand B (rt value or sign-extended immediate).
- alu_sa  in  5  shift amount (instr[10:6]).
- alu_result  out  32  ALU result.
- alu_zero  out  1  high when alu_result == 0.

## Operation
- Register file: 32 entries × 32 bits. Register 0 reads as 0 and ignores writes.
- A write takes effect at the posedge when write=1, rst=0 and wr_addr≠0.
- Read ports are combinational and asynchronous, with two independent ports. Both may address the same register.
- The ALU is purely combinational. All arithmetic is modulo 2^32. There is no overflow flag or trap, so the controller handles ADD/SUB exceptions if ever needed.
- alu_op encoding (decimal):
  - 0 AND
  - 1 OR
  - 2 ADD (a+b)
  - 3 SUB (a−b)
  - 4 SLT (signed a<b → 1 else 0)
  - 5 SLTU (unsigned)
  - 6 SLL (b << sa)
  - 7 SRL (b >> sa, logical)
  - 8 SRA (b >>> sa, arithmetic)
  - 9 SLLV (b << a[4:0])
  - 10 SRLV
  - 11 SRAV
  - 12 XOR
  - 13 NOR
  - 14 LUI ({b[15:0],16'h0})
  - 15–31 → result 0.
- Shifts use only the 5-bit amount. Shift by 0 returns b unchanged.
- alu_zero = (alu_result == 32'h0), including for the undefined ops.

## Timing
- Reset: on the posedge with rst=1, all registers become 0. rst dominates a simultaneous write, which is dropped. After reset, rd_data_a/b and register_v0 read 0.
- Reset mid-operation: the ALU is unaffected because it holds no state.
- Write latency is 1 cycle: data written at edge N is visible on the read ports and register_v0 immediately after edge N.
- Read latency is 0, combinational from rd_addr.
- ALU latency is 0. The controller samples alu_result in the cycle after loading the operands.
- Write and read of the same register in the same cycle: the read returns the old value unless the bypass is compiled in (see Configuration).

## Configuration
- `MIPS_CPU_REGFILE_BYPASS_EN` defined: rd_data_x = wr_data when write=1, rst=0, wr_addr≠0 and wr_addr==rd_addr_x. This gives write-through forwarding. register_v0 is still not bypassed.
- Not defined: reads always return the stored value. This is the default.

## Structure
- Package `mips_cpu_pkg` holds:
  - the `alu_op_t` enum (values above);
  - constants REG_ZERO=0, REG_V0=2, DATA_W=32, REG_ADDR_W=5;
  - the opcode/func enums shared with the controller (ADDIU=6'b001001, LW=6'b100011, SW=6'b101011, R=0; JR=6'b001000, SLL=0).
- One sub-module: `mips_cpu_alu_unit`, the combinational ALU, instantiated by this wrapper. The register array stays inline.

## Test plan
- Reset → all registers 0: rst=1 one cycle, then sweep rd_addr_a 0..31 → rd_data_a=0 and register_v0=0.
- Write/readback and $0 protection:
  - write reg 2 ← 32'hDEADBEEF → next cycle rd_data_b and register_v0 = 32'hDEADBEEF.
  - write reg 0 ← 32'hFFFFFFFF → reads 0.
- rst and write in the same cycle (reg 5 ← 32'h1234) → reg 5 reads 0.
- ADD wrap and zero flag:
  - op 2, a=32'hFFFFFFFF, b=1 → result 0, zero=1.
  - op 2, a=5, b=32'hFFFFFFFE → result 3, zero=0.
- Shifts:
  - op 6, b=32'h00000001, sa=31 → 32'h80000000.
  - op 8, b=32'h80000000, sa=4 → 32'hF8000000.
  - op 7 with the same inputs → 32'h08000000.
- Compare/logic and same-cycle read:
  - op 4, a=−1, b=1 → 1; op 5 with the same inputs → 0; op 13, a=b=0 → 32'hFFFFFFFF.
  - read reg 3 while writing it 32'hA5 → old value, or 32'hA5 with `MIPS_CPU_REGFILE_BYPASS_EN`.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types and constants for the multicycle MIPS32 bus CPU.
//   alu_op_t  : ALU operation select driven by the controller onto alu_op.
//   opcode_t  : primary opcodes (instr[31:26]) decoded by the controller.
//   func_t    : R-type function codes (instr[5:0]) decoded by the controller.
//   REG_ZERO / REG_V0 : architectural register indices used by the datapath.
package mips_cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_V0   = 5'd2;

    typedef enum logic [4:0] {
        ALU_AND  = 5'd0,
        ALU_OR   = 5'd1,
        ALU_ADD  = 5'd2,
        ALU_SUB  = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_SLTU = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLLV = 5'd9,
        ALU_SRLV = 5'd10,
        ALU_SRAV = 5'd11,
        ALU_XOR  = 5'd12,
        ALU_NOR  = 5'd13,
        ALU_LUI  = 5'd14
    } alu_op_t;

    typedef enum logic [5:0] {
        OP_R     = 6'b000000,
        OP_ADDIU = 6'b001001,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL = 6'b000000,
        FN_JR  = 6'b001000
    } func_t;

endpackage

// File: rtl/mips_cpu_alu_unit.sv
// mips_cpu_alu_unit: combinational 32-bit MIPS ALU, no state, no flags
// other than zero.
//   alu_op  in  5   operation select (mips_cpu_pkg::alu_op_t; 15..31 give 0)
//   a       in  32  operand A (rs); a[4:0] is the variable shift amount
//   b       in  32  operand B (rt or sign-extended immediate)
//   sa      in  5   constant shift amount (instr[10:6])
//   result  out 32  operation result, modulo 2^32
//   zero    out 1   result == 0
module mips_cpu_alu_unit
    import mips_cpu_pkg::*;
(
    input  logic [4:0]        alu_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        sa,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic [4:0] vsa;
    assign vsa = a[4:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {31'b0, (a < b)};
            ALU_SLL:  result = b << sa;
            ALU_SRL:  result = b >> sa;
            ALU_SRA:  result = $unsigned($signed(b) >>> sa);
            ALU_SLLV: result = b << vsa;
            ALU_SRLV: result = b >> vsa;
            ALU_SRAV: result = $unsigned($signed(b) >>> vsa);
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_LUI:  result = {b[15:0], 16'h0000};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_cpu_alu_regfile.sv
// mips_cpu_alu_regfile: datapath core of the multicycle MIPS32 CPU.
// 32x32 register file (two async read ports, one sync write port, $0 hard
// zero) plus the combinational ALU.
//   clk, rst        clock; synchronous active-high reset clears all registers
//   write, wr_addr, wr_data          write port, sampled on posedge clk
//   rd_addr_a/rd_data_a, rd_addr_b/rd_data_b   combinational read ports
//   register_v0     live contents of $v0 (never forwarded)
//   alu_op, alu_a, alu_b, alu_sa     ALU inputs
//   alu_result, alu_zero             ALU outputs
// Build option: MIPS_CPU_REGFILE_BYPASS_EN -- when defined, a read of the
// register being written this cycle returns wr_data (write-through).
module mips_cpu_alu_regfile
    import mips_cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic [DATA_W-1:0]     register_v0,
    input  logic [4:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_a,
    input  logic [DATA_W-1:0]     alu_b,
    input  logic [4:0]            alu_sa,
    output logic [DATA_W-1:0]     alu_result,
    output logic                  alu_zero
);

    logic [31:0][DATA_W-1:0] regs;
    logic                    wr_en;

    // $0 is never written, so its storage stays at the reset value of 0.
    assign wr_en = write && !rst && (wr_addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (wr_en)
            regs[wr_addr] <= wr_data;
    end

`ifdef MIPS_CPU_REGFILE_BYPASS_EN
    assign rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
`else
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
`endif

    // $v0 observation port always shows committed state.
    assign register_v0 = regs[REG_V0];

    mips_cpu_alu_unit u_alu (
        .alu_op (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .sa     (alu_sa),
        .result (alu_result),
        .zero   (alu_zero)
    );

endmodule

// File: tb/tb_mips_cpu_alu_regfile.sv
module tb_mips_cpu_alu_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic [31:0] register_v0;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_sa;
    logic [31:0] alu_result;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;

    mips_cpu_alu_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr_a   (rd_addr_a),
        .rd_data_a   (rd_data_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_b   (rd_data_b),
        .register_v0 (register_v0),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sa      (alu_sa),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data);
        write = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        write = 1'b0;
    endtask

    task automatic test_reset();
        wr_reg(5'd7, 32'h1111_2222);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            #1;
            checks++;
            if (rd_data_a !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h want 00000000", i, rd_data_a);
            end
        end
        checks++;
        if (register_v0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_v0: got %h want 00000000", register_v0);
        end
    endtask

    task automatic test_write_readback();
        wr_reg(5'd2, 32'hDEAD_BEEF);
        rd_addr_b = 5'd2;
        #1;
        checks++;
        if (rd_data_b !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_rd_b_reg2: got %h want deadbeef", rd_data_b);
        end
        checks++;
        if (register_v0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_v0: got %h want deadbeef", register_v0);
        end
        wr_reg(5'd9, 32'h0000_0099);
        rd_addr_a = 5'd9;
        #1;
        checks++;
        if (rd_data_a !== 32'h0000_0099) begin
            errors++;
            $display("FAIL wr_rd_a_reg9: got %h want 00000099", rd_data_a);
        end
        wr_reg(5'd0, 32'hFFFF_FFFF);
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        #1;
        checks++;
        if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
            errors++;
            $display("FAIL reg0_protect: got a=%h b=%h want 0", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_reset_dominates();
        wr_reg(5'd5, 32'h5555_5555);
        rst = 1'b1; write = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_1234;
        tick();
        rst = 1'b0; write = 1'b0;
        rd_addr_a = 5'd5;
        #1;
        checks++;
        if (rd_data_a !== 32'h0) begin
            errors++;
            $display("FAIL rst_over_write: got %h want 00000000", rd_data_a);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sa;
        logic [31:0] exp;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t v [20];
        v[0]  = '{5'd2,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000}; // ADD wrap
        v[1]  = '{5'd2,  32'h0000_0005, 32'hFFFF_FFFE, 5'd0,  32'h0000_0003};
        v[2]  = '{5'd6,  32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000}; // SLL
        v[3]  = '{5'd8,  32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000}; // SRA
        v[4]  = '{5'd7,  32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000}; // SRL
        v[5]  = '{5'd4,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001}; // SLT
        v[6]  = '{5'd5,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000}; // SLTU
        v[7]  = '{5'd13, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF}; // NOR
        v[8]  = '{5'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0}; // AND
        v[9]  = '{5'd1,  32'h0F00_0000, 32'h0000_00F0, 5'd0,  32'h0F00_00F0}; // OR
        v[10] = '{5'd3,  32'h0000_0003, 32'h0000_0005, 5'd0,  32'hFFFF_FFFE}; // SUB
        v[11] = '{5'd6,  32'h0,         32'h1234_5678, 5'd0,  32'h1234_5678}; // SLL by 0
        v[12] = '{5'd9,  32'h0000_0024, 32'h0000_000F, 5'd0,  32'h0000_00F0}; // SLLV a[4:0]=4
        v[13] = '{5'd10, 32'h0000_003F, 32'h8000_0000, 5'd0,  32'h0000_0001}; // SRLV 31
        v[14] = '{5'd11, 32'h0000_0001, 32'h8000_0000, 5'd7,  32'hC000_0000}; // SRAV ignores sa
        v[15] = '{5'd12, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F}; // XOR
        v[16] = '{5'd14, 32'h0,         32'hABCD_1234, 5'd0,  32'h1234_0000}; // LUI
        v[17] = '{5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000}; // undefined
        v[18] = '{5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 5'd1,  32'h0000_0000}; // undefined
        v[19] = '{5'd4,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000}; // SLT false
        for (int i = 0; i < 20; i++) begin
            alu_op = v[i].op; alu_a = v[i].a; alu_b = v[i].b; alu_sa = v[i].sa;
            #1;
            checks++;
            if (alu_result !== v[i].exp) begin
                errors++;
                $display("FAIL alu_vec%0d_op%0d: got %h want %h", i, v[i].op, alu_result, v[i].exp);
            end
            checks++;
            if (alu_zero !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL alu_zero_vec%0d: got %b want %b", i, alu_zero, (v[i].exp == 32'h0));
            end
        end
    endtask

    task automatic test_same_cycle_read();
        logic [31:0] exp_a;
        wr_reg(5'd3, 32'h0000_0011);
        wr_reg(5'd2, 32'h0000_0022);
        write = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_00A5;
        rd_addr_a = 5'd3; rd_addr_b = 5'd3;
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
        exp_a = 32'h0000_00A5;
`else
        exp_a = 32'h0000_0011;
`endif
        #1;
        checks++;
        if (rd_data_a !== exp_a || rd_data_b !== exp_a) begin
            errors++;
            $display("FAIL same_cycle_read: got a=%h b=%h want %h", rd_data_a, rd_data_b, exp_a);
        end
        tick();
        write = 1'b0;
        checks++;
        if (rd_data_a !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL after_write_reg3: got %h want 000000a5", rd_data_a);
        end
        // $v0 must show committed state even while being written.
        write = 1'b1; wr_addr = 5'd2; wr_data = 32'h0000_0077;
        #1;
        checks++;
        if (register_v0 !== 32'h0000_0022) begin
            errors++;
            $display("FAIL v0_not_bypassed: got %h want 00000022", register_v0);
        end
        tick();
        write = 1'b0;
        checks++;
        if (register_v0 !== 32'h0000_0077) begin
            errors++;
            $display("FAIL v0_after_write: got %h want 00000077", register_v0);
        end
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        alu_op = '0; alu_a = '0; alu_b = '0; alu_sa = '0;
        tick();
        rst = 1'b0;
        test_reset();
        test_write_readback();
        test_reset_dominates();
        test_alu();
        test_same_cycle_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
